axil_to_cfg_bridge: RTL and testbench

AXIL_TO_CFG_BRIDGE -- requirements
Module: axil_to_cfg_bridge

---
 rtl/axil_to_cfg_bridge.sv | 239 +++++++++++++++++++++++
 tb/tb_axil_to_cfg_bridge.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_to_cfg_bridge.sv
// AXI-Lite slave to single-outstanding config-bus initiator.
// Each AXI-Lite write or read becomes one cfg_wr_o/cfg_rd_o pulse, then waits for ack or timeout.
module axil_to_cfg_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    // AXI-Lite write address
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    // AXI-Lite write data
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    // AXI-Lite write response
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    // AXI-Lite read address
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    // AXI-Lite read data
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    // config bus
    output logic [31:0] cfg_addr_o,
    output logic [31:0] cfg_wdata_o,
    output logic        cfg_wr_o,
    output logic        cfg_rd_o,
    input  logic        cfg_ack_i,
    input  logic [31:0] cfg_rdata_i
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] CNT_LAST    = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        CFG_WR,
        CFG_RD,
        WAIT_ACK,
        WR_RESP,
        RD_RESP
    } state_e;

    state_e          state_q, state_d;
    logic            aw_full_q, aw_full_d;
    logic            w_full_q, w_full_d;
    logic            ar_full_q, ar_full_d;
    logic [AW-1:0]   awaddr_q, awaddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [AW-1:0]   araddr_q, araddr_d;
    logic            is_rd_q, is_rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            awready_q, awready_d;
    logic            wready_q, wready_d;
    logic            arready_q, arready_d;
    logic            bvalid_q, bvalid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic            rvalid_q, rvalid_d;
    logic [1:0]      rresp_q, rresp_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            cfg_wr_q, cfg_wr_d;
    logic            cfg_rd_q, cfg_rd_d;
    logic [AW-1:0]   cfg_addr_q, cfg_addr_d;
    logic [DW-1:0]   cfg_wdata_q, cfg_wdata_d;
    logic            ack_ok;

    // Byte strobes carry no meaning on the config bus.
    logic unused_wstrb;
    assign unused_wstrb = ^s_wstrb;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        aw_full_d   = aw_full_q;
        w_full_d    = w_full_q;
        ar_full_d   = ar_full_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        araddr_d    = araddr_q;
        is_rd_d     = is_rd_q;
        cnt_d       = cnt_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        cfg_wr_d    = 1'b0;
        cfg_rd_d    = 1'b0;
        cfg_addr_d  = cfg_addr_q;
        cfg_wdata_d = cfg_wdata_q;
        ack_ok      = 1'b0;

        if (s_awvalid && awready_q) begin
            aw_full_d = 1'b1;
            awaddr_d  = s_awaddr;
        end
        if (s_wvalid && wready_q) begin
            w_full_d = 1'b1;
            wdata_d  = s_wdata;
        end
        // An AR accepted alongside a completing write waits in its slot behind the write.
        if (s_arvalid && arready_q) begin
            ar_full_d = 1'b1;
            araddr_d  = s_araddr;
        end

        case (state_q)
            IDLE: begin
                if (aw_full_d && w_full_d) begin
                    state_d     = CFG_WR;
                    cfg_wr_d    = 1'b1;
                    cfg_addr_d  = awaddr_d;
                    cfg_wdata_d = wdata_d;
                    is_rd_d     = 1'b0;
                end else if (ar_full_d) begin
                    state_d    = CFG_RD;
                    cfg_rd_d   = 1'b1;
                    cfg_addr_d = araddr_d;
                    ar_full_d  = 1'b0;
                    is_rd_d    = 1'b1;
                end
            end
            CFG_WR, CFG_RD: begin
                state_d = WAIT_ACK;
                cnt_d   = '0;
            end
            WAIT_ACK: begin
                ack_ok = cfg_ack_i;
                if (cfg_ack_i || (cnt_q == CNT_LAST)) begin
                    if (is_rd_q) begin
                        state_d  = RD_RESP;
                        rvalid_d = 1'b1;
                        rresp_d  = ack_ok ? RESP_OKAY : RESP_SLVERR;
                        rdata_d  = ack_ok ? cfg_rdata_i : ERR_RDATA;
                    end else begin
                        state_d  = WR_RESP;
                        bvalid_d = 1'b1;
                        bresp_d  = ack_ok ? RESP_OKAY : RESP_SLVERR;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WR_RESP: begin
                if (s_bready) begin
                    bvalid_d  = 1'b0;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            RD_RESP: begin
                if (s_rready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        awready_d = (state_d == IDLE) && !aw_full_d;
        wready_d  = (state_d == IDLE) && !w_full_d;
        arready_d = (state_d == IDLE) && !ar_full_d && !(aw_full_d && w_full_d);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            aw_full_q   <= 1'b0;
            w_full_q    <= 1'b0;
            ar_full_q   <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            araddr_q    <= '0;
            is_rd_q     <= 1'b0;
            cnt_q       <= '0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            arready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= '0;
            rvalid_q    <= 1'b0;
            rresp_q     <= '0;
            rdata_q     <= '0;
            cfg_wr_q    <= 1'b0;
            cfg_rd_q    <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            aw_full_q   <= aw_full_d;
            w_full_q    <= w_full_d;
            ar_full_q   <= ar_full_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            araddr_q    <= araddr_d;
            is_rd_q     <= is_rd_d;
            cnt_q       <= cnt_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            arready_q   <= arready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            cfg_wr_q    <= cfg_wr_d;
            cfg_rd_q    <= cfg_rd_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_wdata_q <= cfg_wdata_d;
        end
    end

    assign s_awready   = awready_q;
    assign s_wready    = wready_q;
    assign s_arready   = arready_q;
    assign s_bvalid    = bvalid_q;
    assign s_bresp     = bresp_q;
    assign s_rvalid    = rvalid_q;
    assign s_rresp     = rresp_q;
    assign s_rdata     = rdata_q;
    assign cfg_wr_o    = cfg_wr_q;
    assign cfg_rd_o    = cfg_rd_q;
    assign cfg_addr_o  = cfg_addr_q;
    assign cfg_wdata_o = cfg_wdata_q;

endmodule

// File: tb/tb_axil_to_cfg_bridge.sv
// Bench for axil_to_cfg_bridge: a default-timeout instance and a TIMEOUT_CYCLES=4 instance
// share stimulus; use_t4 selects which one is observed.
module tb_axil_to_cfg_bridge;

    logic clk_i = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk_i = ~clk_i;

    logic [31:0] s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_bready = 1'b0;
    logic [31:0] s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_rready = 1'b0;
    logic        cfg_ack_i = 1'b0;
    logic [31:0] cfg_rdata_i = '0;

    logic        def_awready, def_wready, def_arready, def_bvalid, def_rvalid, def_cfg_wr, def_cfg_rd;
    logic [1:0]  def_bresp, def_rresp;
    logic [31:0] def_rdata, def_cfg_addr, def_cfg_wdata;
    logic        t4_awready, t4_wready, t4_arready, t4_bvalid, t4_rvalid, t4_cfg_wr, t4_cfg_rd;
    logic [1:0]  t4_bresp, t4_rresp;
    logic [31:0] t4_rdata, t4_cfg_addr, t4_cfg_wdata;

    axil_to_cfg_bridge dut_def (
        .clk_i(clk_i), .reset_i(reset_i),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(def_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(def_wready),
        .s_bresp(def_bresp), .s_bvalid(def_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(def_arready),
        .s_rdata(def_rdata), .s_rresp(def_rresp), .s_rvalid(def_rvalid), .s_rready(s_rready),
        .cfg_addr_o(def_cfg_addr), .cfg_wdata_o(def_cfg_wdata), .cfg_wr_o(def_cfg_wr),
        .cfg_rd_o(def_cfg_rd), .cfg_ack_i(cfg_ack_i), .cfg_rdata_i(cfg_rdata_i)
    );

    axil_to_cfg_bridge #(.TIMEOUT_CYCLES(4)) dut_t4 (
        .clk_i(clk_i), .reset_i(reset_i),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(t4_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(t4_wready),
        .s_bresp(t4_bresp), .s_bvalid(t4_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(t4_arready),
        .s_rdata(t4_rdata), .s_rresp(t4_rresp), .s_rvalid(t4_rvalid), .s_rready(s_rready),
        .cfg_addr_o(t4_cfg_addr), .cfg_wdata_o(t4_cfg_wdata), .cfg_wr_o(t4_cfg_wr),
        .cfg_rd_o(t4_cfg_rd), .cfg_ack_i(cfg_ack_i), .cfg_rdata_i(cfg_rdata_i)
    );

    logic use_t4 = 1'b0;
    logic        m_awready, m_wready, m_arready, m_bvalid, m_rvalid, m_cfg_wr, m_cfg_rd;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata, m_cfg_addr, m_cfg_wdata;
    assign m_awready   = use_t4 ? t4_awready   : def_awready;
    assign m_wready    = use_t4 ? t4_wready    : def_wready;
    assign m_arready   = use_t4 ? t4_arready   : def_arready;
    assign m_bvalid    = use_t4 ? t4_bvalid    : def_bvalid;
    assign m_rvalid    = use_t4 ? t4_rvalid    : def_rvalid;
    assign m_cfg_wr    = use_t4 ? t4_cfg_wr    : def_cfg_wr;
    assign m_cfg_rd    = use_t4 ? t4_cfg_rd    : def_cfg_rd;
    assign m_bresp     = use_t4 ? t4_bresp     : def_bresp;
    assign m_rresp     = use_t4 ? t4_rresp     : def_rresp;
    assign m_rdata     = use_t4 ? t4_rdata     : def_rdata;
    assign m_cfg_addr  = use_t4 ? t4_cfg_addr  : def_cfg_addr;
    assign m_cfg_wdata = use_t4 ? t4_cfg_wdata : def_cfg_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        s_bready = 1'b0; s_rready = 1'b0; cfg_ack_i = 1'b0;
        cfg_rdata_i = '0; s_wstrb = 4'hF;
    endtask

    task automatic do_reset;
        reset_i = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset_i = 1'b0;
        tick();
    endtask

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata_in;
        int          ack_at;     // cycles after pulse; -1 = never
        int          exp_lat;    // cycles from pulse to response valid
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];
    vec_t v;
    int   lat;
    int   pulses;

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_0001, 32'h0,          1, 2, 2'b00, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0024, 32'h0,          32'hCAFE_F00D, 1, 2, 2'b00, 32'hCAFE_F00D};
        vecs[2] = '{1'b1, 32'h0000_0100, 32'h1357_9BDF, 32'h0,          3, 4, 2'b00, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0030, 32'h0,          32'h0BAD_C0DE, 4, 5, 2'b00, 32'h0BAD_C0DE};
        vecs[4] = '{1'b0, 32'h0000_0040, 32'h0,          32'h1111_2222, 0, 5, 2'b10, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 32'h0000_0044, 32'h0F0F_0F0F, 32'h0,         -1, 5, 2'b10, 32'h0};
        vecs[6] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0,          2, 3, 2'b00, 32'h0};

        // Reset state and ready rise on first edge after release.
        clear_inputs();
        use_t4 = 1'b0;
        tick();
        check1("rst_awready", m_awready, 1'b0);
        check1("rst_arready", m_arready, 1'b0);
        check1("rst_bvalid", m_bvalid, 1'b0);
        check1("rst_rvalid", m_rvalid, 1'b0);
        check32("rst_cfg_addr", m_cfg_addr, 32'h0);
        tick();
        reset_i = 1'b0;
        check1("rel_wready_before_edge", m_wready, 1'b0);
        tick();
        check1("rel_awready", m_awready, 1'b1);
        check1("rel_wready", m_wready, 1'b1);
        check1("rel_arready", m_arready, 1'b1);

        // Table-driven transactions on the TIMEOUT_CYCLES=4 instance.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            use_t4 = 1'b1;
            v = vecs[i];
            check1("vec_ready", v.is_wr ? m_awready : m_arready, 1'b1);
            if (v.is_wr) begin
                s_awaddr = v.addr; s_awvalid = 1'b1;
                s_wdata = v.wdata; s_wvalid = 1'b1;
            end else begin
                s_araddr = v.addr; s_arvalid = 1'b1;
            end
            tick();
            s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
            check1("vec_cfg_wr", m_cfg_wr, v.is_wr);
            check1("vec_cfg_rd", m_cfg_rd, ~v.is_wr);
            check32("vec_cfg_addr", m_cfg_addr, v.addr);
            if (v.is_wr) check32("vec_cfg_wdata", m_cfg_wdata, v.wdata);
            cfg_rdata_i = v.rdata_in;
            cfg_ack_i = (v.ack_at == 0);
            lat = 0;
            pulses = 0;
            for (int k = 1; k <= 12 && lat == 0; k++) begin
                tick();
                cfg_ack_i = 1'b0;
                pulses += int'(m_cfg_wr) + int'(m_cfg_rd);
                if (v.is_wr ? m_bvalid : m_rvalid) lat = k;
                else cfg_ack_i = (k == v.ack_at);
            end
            cfg_rdata_i = '0;
            check32("vec_latency", 32'(lat), 32'(v.exp_lat));
            check32("vec_extra_pulses", 32'(pulses), 32'h0);
            if (v.is_wr) begin
                check32("vec_bresp", 32'(m_bresp), 32'(v.exp_resp));
                s_bready = 1'b1;
            end else begin
                check32("vec_rresp", 32'(m_rresp), 32'(v.exp_resp));
                check32("vec_rdata", m_rdata, v.exp_rdata);
                s_rready = 1'b1;
            end
            tick();
            s_bready = 1'b0; s_rready = 1'b0;
            check1("vec_valid_drop", v.is_wr ? m_bvalid : m_rvalid, 1'b0);
            check1("vec_idle_awready", m_awready, 1'b1);
        end

        // W first, AW three cycles later: single pulse only once both are held.
        do_reset();
        use_t4 = 1'b0;
        s_wdata = 32'h5555_AAAA; s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        check1("split_wready_low", m_wready, 1'b0);
        check1("split_awready_high", m_awready, 1'b1);
        pulses = int'(m_cfg_wr);
        tick();
        pulses += int'(m_cfg_wr);
        tick();
        pulses += int'(m_cfg_wr);
        s_awaddr = 32'h0000_0080; s_awvalid = 1'b1;
        check32("split_early_pulse", 32'(pulses), 32'h0);
        tick();
        s_awvalid = 1'b0;
        check1("split_cfg_wr", m_cfg_wr, 1'b1);
        check32("split_addr", m_cfg_addr, 32'h0000_0080);
        check32("split_wdata", m_cfg_wdata, 32'h5555_AAAA);
        tick();
        cfg_ack_i = 1'b1;
        pulses = int'(m_cfg_wr);
        tick();
        cfg_ack_i = 1'b0;
        pulses += int'(m_cfg_wr);
        check1("split_bvalid", m_bvalid, 1'b1);
        check32("split_bresp", 32'(m_bresp), 32'h0);
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        check32("split_extra_pulses", 32'(pulses + int'(m_cfg_wr)), 32'h0);

        // Slow ack and back-pressured read data stays stable.
        do_reset();
        use_t4 = 1'b0;
        s_araddr = 32'h0000_0020; s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        check1("slow_cfg_rd", m_cfg_rd, 1'b1);
        check32("slow_addr", m_cfg_addr, 32'h0000_0020);
        cfg_rdata_i = 32'h1234_5678;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 4) check32("slow_addr_hold", m_cfg_addr, 32'h0000_0020);
            if (k == 5) begin
                check1("slow_no_early_rvalid", m_rvalid, 1'b0);
                cfg_ack_i = 1'b1;
            end
        end
        tick();
        cfg_ack_i = 1'b0;
        cfg_rdata_i = 32'h0;
        for (int j = 0; j < 3; j++) begin
            check1("slow_rvalid_held", m_rvalid, 1'b1);
            check32("slow_rdata", m_rdata, 32'h1234_5678);
            check32("slow_rresp", 32'(m_rresp), 32'h0);
            tick();
        end
        check1("slow_rvalid_at_ready", m_rvalid, 1'b1);
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        check1("slow_rvalid_drop", m_rvalid, 1'b0);

        // Read timeout followed by late and spurious acks.
        do_reset();
        use_t4 = 1'b1;
        s_araddr = 32'h0000_0050; s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        check1("to_rvalid", m_rvalid, 1'b1);
        check32("to_rresp", 32'(m_rresp), 32'h2);
        check32("to_rdata", m_rdata, 32'hDEAD_BEEF);
        tick();
        tick();
        cfg_ack_i = 1'b1;
        cfg_rdata_i = 32'h9999_9999;
        tick();
        cfg_ack_i = 1'b0;
        check1("late_rvalid", m_rvalid, 1'b1);
        check32("late_rresp", 32'(m_rresp), 32'h2);
        check32("late_rdata", m_rdata, 32'hDEAD_BEEF);
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        check1("late_arready", m_arready, 1'b1);
        cfg_ack_i = 1'b1;
        tick();
        cfg_ack_i = 1'b0;
        check1("spur_rvalid", m_rvalid, 1'b0);
        check1("spur_bvalid", m_bvalid, 1'b0);
        check1("spur_cfg_rd", m_cfg_rd, 1'b0);
        check1("spur_awready", m_awready, 1'b1);

        // Write in flight while AR pending: write first, AR accepted only back in IDLE.
        do_reset();
        use_t4 = 1'b0;
        s_awaddr = 32'h0000_0060; s_awvalid = 1'b1;
        s_wdata = 32'hABCD_0001; s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_araddr = 32'h0000_0064; s_arvalid = 1'b1;
        check1("prio_cfg_wr", m_cfg_wr, 1'b1);
        check1("prio_arready_wr", m_arready, 1'b0);
        tick();
        check1("prio_arready_wait", m_arready, 1'b0);
        cfg_ack_i = 1'b1;
        tick();
        cfg_ack_i = 1'b0;
        check1("prio_bvalid", m_bvalid, 1'b1);
        check1("prio_arready_resp", m_arready, 1'b0);
        check1("prio_no_cfg_rd", m_cfg_rd, 1'b0);
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        check1("prio_arready_idle", m_arready, 1'b1);
        tick();
        s_arvalid = 1'b0;
        check1("prio_cfg_rd", m_cfg_rd, 1'b1);
        check32("prio_rd_addr", m_cfg_addr, 32'h0000_0064);
        cfg_rdata_i = 32'h7777_0001;
        tick();
        cfg_ack_i = 1'b1;
        tick();
        cfg_ack_i = 1'b0;
        check1("prio_rvalid", m_rvalid, 1'b1);
        check32("prio_rdata", m_rdata, 32'h7777_0001);
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;

        // Reset during WAIT_ACK: outputs clear without a clock edge, no response later.
        do_reset();
        use_t4 = 1'b0;
        s_awaddr = 32'h0000_0070; s_awvalid = 1'b1;
        s_wdata = 32'h0BB0_0BB0; s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        tick();
        check32("mid_addr_hold", m_cfg_addr, 32'h0000_0070);
        #2;
        reset_i = 1'b1;
        #1;
        check32("mid_cfg_addr", m_cfg_addr, 32'h0);
        check32("mid_cfg_wdata", m_cfg_wdata, 32'h0);
        check1("mid_awready", m_awready, 1'b0);
        check1("mid_wready", m_wready, 1'b0);
        check1("mid_cfg_wr", m_cfg_wr, 1'b0);
        tick();
        reset_i = 1'b0;
        cfg_ack_i = 1'b1;
        tick();
        cfg_ack_i = 1'b0;
        check1("mid_ready_after", m_awready, 1'b1);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            pulses += int'(m_bvalid) + int'(m_rvalid) + int'(m_cfg_wr) + int'(m_cfg_rd);
            tick();
        end
        check32("mid_no_response", 32'(pulses), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
